// File: rtl/cacheline_mem_arbiter.sv
// rtl/cacheline_mem_arbiter.sv - shares one cacheline memory port between I-cache, D-cache and eviction write buffer
// Grants one client at a time; a D read never overtakes a queued writeback of the same line.
module cacheline_mem_arbiter #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int EWB_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    input  logic              ewb_write,
    input  logic [ADDR_W-1:0] ewb_addr,
    input  logic [LINE_W-1:0] ewb_wdata,
    output logic              ewb_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, SERVE_EWB} state_t;

    localparam int               CNT_W    = $clog2(EWB_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(EWB_MAX_WAIT);

    state_t            state_q;
    state_t            grant_d;
    logic              last_d_q;
    logic [CNT_W-1:0]  ewb_wait_cnt_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_addr_q;
    logic [LINE_W-1:0] pmem_wdata_q;
    logic              d_req;

    assign d_req = d_read | d_write;

    // Only consulted while IDLE; the first matching rule wins.
    always_comb begin
        grant_d = IDLE;
        if (ewb_write && d_read && (d_addr == ewb_addr)) begin
            grant_d = SERVE_EWB;
        end else if (ewb_write && (ewb_wait_cnt_q == WAIT_MAX)) begin
            grant_d = SERVE_EWB;
        end else if (i_read && d_req) begin
            grant_d = last_d_q ? SERVE_I : SERVE_D;
        end else if (i_read) begin
            grant_d = SERVE_I;
        end else if (d_req) begin
            grant_d = SERVE_D;
        end else if (ewb_write) begin
            grant_d = SERVE_EWB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            ewb_wait_cnt_q <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_addr_q    <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= grant_d;
                    if ((grant_d == SERVE_I || grant_d == SERVE_D) && ewb_write &&
                        (ewb_wait_cnt_q != WAIT_MAX)) begin
                        ewb_wait_cnt_q <= ewb_wait_cnt_q + CNT_W'(1);
                    end
                    case (grant_d)
                        SERVE_I: begin
                            pmem_read_q <= 1'b1;
                            pmem_addr_q <= i_addr;
                        end
                        SERVE_D: begin
                            // Direction is frozen here so a mid-flight request change cannot flip it.
                            pmem_read_q  <= ~d_write;
                            pmem_write_q <= d_write;
                            pmem_addr_q  <= d_addr;
                            pmem_wdata_q <= d_write ? d_wdata : '0;
                        end
                        SERVE_EWB: begin
                            pmem_write_q <= 1'b1;
                            pmem_addr_q  <= ewb_addr;
                            pmem_wdata_q <= ewb_wdata;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        pmem_addr_q  <= '0;
                        pmem_wdata_q <= '0;
                        if (state_q == SERVE_I) begin
                            last_d_q <= 1'b0;
                        end else if (state_q == SERVE_D) begin
                            last_d_q <= 1'b1;
                        end else begin
                            ewb_wait_cnt_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;

    assign i_rdata  = pmem_rdata;
    assign d_rdata  = pmem_rdata;
    assign i_resp   = (state_q == SERVE_I)   && pmem_resp;
    assign d_resp   = (state_q == SERVE_D)   && pmem_resp;
    assign ewb_resp = (state_q == SERVE_EWB) && pmem_resp;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb/tb_cacheline_mem_arbiter.sv - scoreboard bench for cacheline_mem_arbiter
module tb_cacheline_mem_arbiter;

    localparam int MAXW = 4;

    typedef struct {
        int          client;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, ewb_write;
    logic [31:0]  i_addr, d_addr, ewb_addr;
    logic [255:0] d_wdata, ewb_wdata;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp, ewb_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] di_q[$];
    txn_t        dd_q[$];
    txn_t        de_q[$];
    logic [31:0] mi_q[$];
    txn_t        md_q[$];
    txn_t        me_q[$];
    txn_t        exp_q[$];
    logic        m_last_d;
    int          m_wait;

    logic         mem_stall = 1'b0;
    logic         spurious  = 1'b0;
    int           busy = 0;
    int           lat  = 0;
    logic [255:0] last_rdata = '0;

    logic cmd_prev = 1'b0;
    int   cur = 3;
    txn_t e;

    cacheline_mem_arbiter #(.LINE_W(256), .ADDR_W(32), .EWB_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .ewb_write(ewb_write), .ewb_addr(ewb_addr), .ewb_wdata(ewb_wdata), .ewb_resp(ewb_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        return a & ~32'h1f;
    endfunction

    function automatic logic [2:0] onehot(input int c);
        case (c)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic add_i(input logic [31:0] a);
        di_q.push_back(a);
        mi_q.push_back(a);
    endtask

    task automatic add_d(input logic wr, input logic [31:0] a, input logic [255:0] w);
        txn_t t;
        t.client = 1; t.rd = ~wr; t.wr = wr; t.addr = a; t.wdata = wr ? w : '0;
        dd_q.push_back(t);
        md_q.push_back(t);
    endtask

    task automatic add_e(input logic [31:0] a, input logic [255:0] w);
        txn_t t;
        t.client = 2; t.rd = 1'b0; t.wr = 1'b1; t.addr = a; t.wdata = w;
        de_q.push_back(t);
        me_q.push_back(t);
    endtask

    // Reference: held requests, rules applied to the current heads until every queue drains.
    task automatic predict();
        while (mi_q.size() > 0 || md_q.size() > 0 || me_q.size() > 0) begin
            bit ip, dp, ep;
            int g;
            txn_t t;
            ip = mi_q.size() > 0;
            dp = md_q.size() > 0;
            ep = me_q.size() > 0;
            if (ep && dp && md_q[0].rd && md_q[0].addr == me_q[0].addr) g = 2;
            else if (ep && m_wait == MAXW) g = 2;
            else if (ip && dp) g = m_last_d ? 0 : 1;
            else if (ip) g = 0;
            else if (dp) g = 1;
            else g = 2;
            if (g != 2 && ep && m_wait < MAXW) m_wait++;
            if (g == 0) begin
                t.client = 0; t.rd = 1'b1; t.wr = 1'b0; t.addr = mi_q.pop_front(); t.wdata = '0;
                m_last_d = 1'b0;
            end else if (g == 1) begin
                t = md_q.pop_front();
                m_last_d = 1'b1;
            end else begin
                t = me_q.pop_front();
                m_wait = 0;
            end
            exp_q.push_back(t);
        end
    endtask

    task automatic drive_heads();
        i_read = di_q.size() > 0;
        i_addr = i_read ? di_q[0] : '0;
        if (dd_q.size() > 0) begin
            d_read = dd_q[0].rd; d_write = dd_q[0].wr; d_addr = dd_q[0].addr; d_wdata = dd_q[0].wdata;
        end else begin
            d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        end
        if (de_q.size() > 0) begin
            ewb_write = 1'b1; ewb_addr = de_q[0].addr; ewb_wdata = de_q[0].wdata;
        end else begin
            ewb_write = 1'b0; ewb_addr = '0; ewb_wdata = '0;
        end
    endtask

    task automatic run_round();
        int budget;
        budget = 400;
        predict();
        while ((di_q.size() > 0 || dd_q.size() > 0 || de_q.size() > 0) && budget > 0) begin
            drive_heads();
            @(negedge clk); #2;
            if (i_resp && di_q.size() > 0) void'(di_q.pop_front());
            if (d_resp && dd_q.size() > 0) void'(dd_q.pop_front());
            if (ewb_resp && de_q.size() > 0) void'(de_q.pop_front());
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL round_timeout: %0d requests still pending, required 0",
                     di_q.size() + dd_q.size() + de_q.size());
            di_q.delete(); dd_q.delete(); de_q.delete();
        end
        drive_heads();
        repeat (2) begin @(negedge clk); #2; end
    endtask

    // Memory model: random latency, random read data, optional stall and out-of-turn pulse.
    always @(negedge clk) begin
        pmem_resp = 1'b0;
        if (!rst_n || mem_stall) begin
            busy = 0;
        end else if (pmem_read || pmem_write) begin
            if (busy == 0) begin busy = 1; lat = $urandom_range(0, 5); end
            if (lat == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rand_line();
                last_rdata = pmem_rdata;
                busy       = 0;
            end else begin
                lat--;
            end
        end else if (spurious) begin
            pmem_resp = 1'b1;
            spurious  = 1'b0;
        end
    end

    always begin
        @(negedge clk); #1;
        if (!rst_n) begin
            cmd_prev = 1'b0;
            cur      = 3;
        end else begin
            logic cmd;
            cmd = pmem_read | pmem_write;
            if (pmem_read && pmem_write) chk("rd_wr_exclusive", 1, 0);
            if (cmd && !cmd_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_grant: addr %h with no expected grant", pmem_addr);
                    cur = 3;
                end else begin
                    e   = exp_q.pop_front();
                    cur = e.client;
                    chk("grant_read", pmem_read, e.rd);
                    chk("grant_write", pmem_write, e.wr);
                    chk("grant_addr", pmem_addr, e.addr);
                    if (e.wr) chk("grant_wdata", pmem_wdata, e.wdata);
                end
            end
            if (!cmd) begin
                chk("idle_addr", pmem_addr, 0);
                chk("idle_wdata", pmem_wdata, 0);
            end
            if (pmem_resp || i_resp || d_resp || ewb_resp)
                chk("resp_vec", {i_resp, d_resp, ewb_resp}, (pmem_resp && cmd) ? onehot(cur) : 3'b000);
            if (i_resp) chk("i_rdata", i_rdata, last_rdata);
            if (d_resp && pmem_read) chk("d_rdata", d_rdata, last_rdata);
            cmd_prev = cmd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        pmem_rdata = '0;
        di_q.delete(); dd_q.delete(); de_q.delete();
        drive_heads();
        m_last_d = 1'b0;
        m_wait   = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_resp", {i_resp, d_resp, ewb_resp}, 0);
        chk("rst_pmem_cmd", {pmem_read, pmem_write}, 0);
        chk("rst_pmem_addr", pmem_addr, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk); #2;

        add_i(32'h1000);
        run_round();

        add_i(32'h0100); add_i(32'h0120);
        add_d(1'b0, 32'h0200, '0); add_d(1'b0, 32'h0220, '0);
        run_round();

        add_e(32'h2000, rand_line());
        add_d(1'b0, 32'h2000, '0);
        add_i(32'h0300);
        run_round();

        add_e(32'h3000, rand_line());
        for (int k = 0; k < 3; k++) begin
            add_i(32'h4000 + 32'(k) * 32'h20);
            add_d(1'b0, 32'h5000 + 32'(k) * 32'h20, '0);
        end
        run_round();

        add_d(1'b1, 32'h0040, {8{32'h12345678}});
        run_round();

        spurious = 1'b1;
        repeat (2) begin @(negedge clk); #2; end

        mem_stall = 1'b1;
        add_d(1'b0, 32'h0080, '0);
        predict();
        drive_heads();
        n = 0;
        while (!pmem_read && n < 20) begin @(negedge clk); #2; n++; end
        chk("rst_setup_cmd", pmem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cmd", {pmem_read, pmem_write}, 0);
        chk("async_rst_addr", pmem_addr, 0);
        chk("async_rst_resp", {i_resp, d_resp, ewb_resp}, 0);
        dd_q.delete();
        exp_q.delete();
        drive_heads();
        repeat (2) begin @(negedge clk); #2; end
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        m_last_d  = 1'b0;
        m_wait    = 0;
        @(negedge clk); #2;
        add_i(32'h0500);
        run_round();

        for (int r = 0; r < 40; r++) begin
            int ni, nd, ne;
            logic [31:0] ea;
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            ne = $urandom_range(0, 2);
            ea = rand_addr();
            for (int k = 0; k < ne; k++) add_e((k == 0) ? ea : rand_addr(), rand_line());
            for (int k = 0; k < nd; k++) begin
                logic wr;
                wr = ($urandom_range(0, 2) == 0);
                add_d(wr, (ne > 0 && $urandom_range(0, 1) == 0) ? ea : rand_addr(), rand_line());
            end
            for (int k = 0; k < ni; k++) add_i(rand_addr());
            if (ni + nd + ne == 0) add_i(rand_addr());
            run_round();
        end

        repeat (3) begin @(negedge clk); #2; end
        chk("scoreboard_drained", 256'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
Shares the single physical-memory cacheline port between the instruction cache (line reads), the data cache (line reads/writes) and the eviction write buffer (dirty-line writebacks). Sits between the L1 caches/EWB and the cacheline adaptor. It grants one requester at a time, routes the 256-bit line and response, and enforces ordering so a D-cache read never bypasses a pending writeback of the same line.

Parameters:
LINE_W, 256, cacheline width in bits
ADDR_W, 32, line address width (low 5 bits always zero)
EWB_MAX_WAIT, 4, consecutive grants to I/D while EWB waits before EWB is forced first

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line read request, level, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write request (never together with d_read)
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
ewb_write  in  1  EWB writeback request, held until ewb_resp
ewb_addr  in  ADDR_W  EWB line address
ewb_wdata  in  LINE_W  EWB write line
ewb_resp  out  1  one-cycle completion pulse to EWB
pmem_read  out  1  memory line read
pmem_write  out  1  memory line write
pmem_addr  out  ADDR_W  memory line address
pmem_wdata  out  LINE_W  memory write line
pmem_rdata  in  LINE_W  memory read line
pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, SERVE_EWB; 2-bit state register, async reset to IDLE.
- Reset values: all *_resp, pmem_read, pmem_write = 0; pmem_addr, pmem_wdata = 0; last_served = I; ewb_wait_cnt = 0.
- pmem_read/pmem_write/pmem_addr/pmem_wdata driven from the current state only (no combinational path from request inputs); all zero in IDLE.
- IDLE arbitration, first match wins:
  1. ewb_write and d_read and d_addr == ewb_addr -> SERVE_EWB (ordering hazard).
  2. ewb_write and ewb_wait_cnt == EWB_MAX_WAIT -> SERVE_EWB.
  3. i_read and (d_read|d_write): round-robin; go to the one not equal to last_served.
  4. only I or only D requesting -> that one.
  5. ewb_write -> SERVE_EWB.
- Grant latency: request sampled in IDLE at cycle N; pmem command asserted from cycle N+1.
- In SERVE_x: hold command until pmem_resp. In the pmem_resp cycle, pulse the granted client's resp for exactly 1 cycle; rdata = pmem_rdata in that cycle (combinational pass-through, valid only with resp). Next state IDLE. Minimum back-to-back spacing: one IDLE cycle between transactions.
- i_rdata/d_rdata outputs track pmem_rdata continuously; clients sample only on resp.
- last_served updates to I or D on completion of SERVE_I/SERVE_D; unchanged by EWB.
- ewb_wait_cnt: +1 on each I/D grant issued while ewb_write high, saturating at EWB_MAX_WAIT; cleared to 0 on SERVE_EWB completion.
- SERVE_D issues pmem_write when d_write, else pmem_read; direction latched at grant.
- Requests dropped mid-transaction are protocol violations; the arbiter still completes the transaction and pulses resp.
- pmem_resp in IDLE: ignored, no client resp.
- rst_n asserted mid-transaction: immediate return to IDLE, all outputs zero; in-flight memory op abandoned (memory is reset with the system).

Test Plan:
- Only i_read, i_addr=0x1000; pmem_resp after 5 cycles with rdata=0xA5..A5 -> pmem_read=1, pmem_addr=0x1000 from cycle 1; i_resp one cycle with i_rdata=0xA5..A5; d_resp=ewb_resp=0.
- i_read and d_read both held continuously, last_served=I after reset -> grant order D, I, D, I; one IDLE cycle between each.
- ewb_write addr 0x2000 pending, d_read addr 0x2000 same cycle, i_read also high -> SERVE_EWB first (pmem_write, ewb_wdata), then D read.
- ewb_write 0x3000 held while I and D continuously request -> after exactly 4 I/D grants, EWB granted; counter returns to 0.
- d_write addr 0x40 wdata 0x1234.. -> pmem_write=1, pmem_wdata matches, pmem_read=0; d_resp on pmem_resp.
- rst_n low during SERVE_D -> all outputs 0 asynchronously; after release, pending i_read granted normally with no spurious resp.
